// File: rtl/uart_ahb_pkg.sv
// Shared definitions for the UART command bridge to AHB-Lite.
// Holds the command opcodes, response codes, AHB encodings and the state
// enums used by the frame FSM and the bus sequencer.
package uart_ahb_pkg;

    localparam logic [7:0] OP_WRITE      = 8'h57;
    localparam logic [7:0] OP_READ       = 8'h52;

    localparam logic [7:0] RSP_BAD_OP    = 8'h3F;
    localparam logic [7:0] RSP_UNALIGNED = 8'hE1;
    localparam logic [7:0] RSP_BUS_ERR   = 8'hE0;
    localparam logic [7:0] RSP_WR_OK     = 8'h4B;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD_ADDR = 3'd1,
        ST_CMD_DATA = 3'd2,
        ST_AHB_ADDR = 3'd3,
        ST_AHB_DATA = 3'd4,
        ST_RESP     = 3'd5
    } frame_state_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_ADDR = 2'd1,
        PH_DATA = 2'd2
    } ahb_phase_e;

    // Word transfers need the two low address bits clear.
    function automatic logic word_aligned(input logic [1:0] addr_low);
        return (addr_low == 2'b00);
    endfunction

endpackage

// File: rtl/ahb_master_if.sv
// Single-transfer AHB-Lite master sequencer.
// Ports: HCLK/HRESET; start + start_addr/start_write/start_wdata launch one
// transfer; done pulses (combinationally) on the completing data-phase cycle
// with error = HRESP and rdata = HRDATA; HADDR/HTRANS/HWRITE/HWDATA are
// registered, HSIZE/HBURST/HPROT are constant.
module ahb_master_if
    import uart_ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic        start_write,
    input  logic [31:0] start_wdata,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    ahb_phase_e  phase_r;
    ahb_phase_e  phase_next_s;
    logic [31:0] haddr_r;
    logic [31:0] hwdata_r;
    logic        hwrite_r;
    logic [1:0]  htrans_r;

    // Phase register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            phase_r <= PH_IDLE;
        end else begin
            phase_r <= phase_next_s;
        end
    end

    // Next phase: address phase holds while HREADY is low, data phase waits for HREADY.
    always_comb begin
        phase_next_s = phase_r;
        case (phase_r)
            PH_IDLE: begin
                if (start) phase_next_s = PH_ADDR;
                else       phase_next_s = PH_IDLE;
            end
            PH_ADDR: begin
                if (HREADY) phase_next_s = PH_DATA;
                else        phase_next_s = PH_ADDR;
            end
            PH_DATA: begin
                if (HREADY) phase_next_s = PH_IDLE;
                else        phase_next_s = PH_DATA;
            end
            default: phase_next_s = PH_IDLE;
        endcase
    end

    // Bus output registers: latched on start, HTRANS drops to IDLE once the address is taken.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            haddr_r  <= 32'h0000_0000;
            hwdata_r <= 32'h0000_0000;
            hwrite_r <= 1'b0;
            htrans_r <= HTRANS_IDLE;
        end else if ((phase_r == PH_IDLE) && start) begin
            haddr_r  <= start_addr;
            hwdata_r <= start_wdata;
            hwrite_r <= start_write;
            htrans_r <= HTRANS_NONSEQ;
        end else if ((phase_r == PH_ADDR) && HREADY) begin
            htrans_r <= HTRANS_IDLE;
        end
    end

    assign done   = (phase_r == PH_DATA) && HREADY;
    assign error  = done && HRESP;
    assign rdata  = HRDATA;

    assign HADDR  = haddr_r;
    assign HTRANS = htrans_r;
    assign HWRITE = hwrite_r;
    assign HWDATA = hwdata_r;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_DATA;

endmodule

// File: rtl/uart_ahb_master.sv
// UART byte-stream command decoder driving one AHB-Lite transfer per frame.
// Ports: HCLK/HRESET; rx_data/rx_valid/rx_ready command byte input;
// tx_data/tx_valid/tx_ready response byte output; AHB-Lite master signals
// HADDR..HRESP; busy is high whenever the frame FSM is not IDLE.
// Frames: 0x57 A3 A2 A1 A0 D3 D2 D1 D0 (write), 0x52 A3 A2 A1 A0 (read).
module uart_ahb_master
    import uart_ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    frame_state_e    state_r;
    frame_state_e    state_next_s;
    logic            write_r;
    logic [31:0]     addr_r;
    logic [31:0]     data_r;
    logic [1:0]      byte_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [7:0]      tx_data_r;
    logic [23:0]     rsp_rest_r;
    logic [1:0]      rsp_left_r;
    logic            tx_valid_r;
    logic            rx_ready_r;
    logic            busy_r;

    logic            rx_accept_s;
    logic            tx_take_s;
    logic            last_byte_s;
    logic            timeout_s;
    logic            in_cmd_s;
    logic [31:0]     addr_next_s;
    logic [31:0]     data_next_s;
    logic [31:0]     start_addr_s;
    logic            start_s;
    logic            rsp_load_s;
    logic [31:0]     rsp_word_s;
    logic [1:0]      rsp_cnt_s;
    logic            bus_done_s;
    logic            bus_err_s;
    logic [31:0]     bus_rdata_s;

    // rx_ready_r is registered from the next state, so it always matches state_r.
    assign rx_accept_s  = rx_valid && rx_ready_r;
    assign tx_take_s    = tx_valid_r && tx_ready;
    assign last_byte_s  = (byte_cnt_r == 2'd3);
    assign in_cmd_s     = (state_r == ST_CMD_ADDR) || (state_r == ST_CMD_DATA);
    assign timeout_s    = in_cmd_s && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
    // Shift-in values including the byte being accepted this cycle, so the
    // transfer can launch on the same edge that takes the last frame byte.
    assign addr_next_s  = {addr_r[23:0], rx_data};
    assign data_next_s  = {data_r[23:0], rx_data};
    assign start_addr_s = write_r ? addr_r : addr_next_s;

    // Frame state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame FSM next state, bus launch and response selection.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        rsp_load_s   = 1'b0;
        rsp_word_s   = 32'h0000_0000;
        rsp_cnt_s    = 2'd0;
        case (state_r)
            ST_IDLE: begin
                if (rx_accept_s) begin
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        state_next_s = ST_CMD_ADDR;
                    end else begin
                        state_next_s = ST_RESP;
                        rsp_load_s   = 1'b1;
                        rsp_word_s   = {RSP_BAD_OP, 24'h00_0000};
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CMD_ADDR, ST_CMD_DATA: begin
                if (rx_accept_s) begin
                    if (!last_byte_s) begin
                        state_next_s = state_r;
                    end else if ((state_r == ST_CMD_ADDR) && write_r) begin
                        state_next_s = ST_CMD_DATA;
                    end else if (word_aligned(start_addr_s[1:0])) begin
                        state_next_s = ST_AHB_ADDR;
                        start_s      = 1'b1;
                    end else begin
                        state_next_s = ST_RESP;
                        rsp_load_s   = 1'b1;
                        rsp_word_s   = {RSP_UNALIGNED, 24'h00_0000};
                    end
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_AHB_ADDR: begin
                if (HREADY) state_next_s = ST_AHB_DATA;
                else        state_next_s = ST_AHB_ADDR;
            end
            ST_AHB_DATA: begin
                if (bus_done_s) begin
                    state_next_s = ST_RESP;
                    rsp_load_s   = 1'b1;
                    if (bus_err_s) begin
                        rsp_word_s = {RSP_BUS_ERR, 24'h00_0000};
                    end else if (write_r) begin
                        rsp_word_s = {RSP_WR_OK, 24'h00_0000};
                    end else begin
                        rsp_word_s = bus_rdata_s;
                        rsp_cnt_s  = 2'd3;
                    end
                end else begin
                    state_next_s = ST_AHB_DATA;
                end
            end
            ST_RESP: begin
                if (tx_take_s && (rsp_left_r == 2'd0)) state_next_s = ST_IDLE;
                else                                   state_next_s = ST_RESP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Frame datapath: shift registers, timeout counter, response buffer and status outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            write_r    <= 1'b0;
            addr_r     <= 32'h0000_0000;
            data_r     <= 32'h0000_0000;
            byte_cnt_r <= 2'd0;
            to_cnt_r   <= '0;
            tx_data_r  <= 8'h00;
            rsp_rest_r <= 24'h00_0000;
            rsp_left_r <= 2'd0;
            tx_valid_r <= 1'b0;
            rx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            busy_r     <= (state_next_s != ST_IDLE);
            rx_ready_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_CMD_ADDR) ||
                          (state_next_s == ST_CMD_DATA);

            if (rx_accept_s && (state_r == ST_IDLE)) begin
                write_r    <= (rx_data == OP_WRITE);
                byte_cnt_r <= 2'd0;
            end else if (rx_accept_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                if (state_r == ST_CMD_ADDR) addr_r <= addr_next_s;
                else                        data_r <= data_next_s;
            end

            if (rx_accept_s || !in_cmd_s) to_cnt_r <= '0;
            else                          to_cnt_r <= to_cnt_r + TO_W'(1);

            if (rsp_load_s) begin
                tx_data_r  <= rsp_word_s[31:24];
                rsp_rest_r <= rsp_word_s[23:0];
                rsp_left_r <= rsp_cnt_s;
                tx_valid_r <= 1'b1;
            end else if (tx_take_s) begin
                if (rsp_left_r == 2'd0) begin
                    tx_valid_r <= 1'b0;
                end else begin
                    tx_data_r  <= rsp_rest_r[23:16];
                    rsp_rest_r <= {rsp_rest_r[15:0], 8'h00};
                    rsp_left_r <= rsp_left_r - 2'd1;
                end
            end
        end
    end

    ahb_master_if u_bus (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .start       (start_s),
        .start_addr  (start_addr_s),
        .start_write (write_r),
        .start_wdata (data_next_s),
        .done        (bus_done_s),
        .error       (bus_err_s),
        .rdata       (bus_rdata_s),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    assign rx_ready = rx_ready_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_uart_ahb_master.sv
// Directed bench for uart_ahb_master: a table of command frames with their
// expected response bytes and bus transfer, plus hand-written sequences for
// latency, timeout abort, transmitter back-pressure and reset mid-transfer.
module tb_uart_ahb_master;

    localparam int TO = 50;

    logic        HCLK;
    logic        HRESET;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;

    uart_ahb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .busy(busy)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int total = 0;
    int bad   = 0;

    // slave configuration (written by the main sequence only while idle)
    logic [3:0]  cfg_dw    = 4'd0;
    logic [3:0]  cfg_aw    = 4'd0;
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    // slave observations
    int          nonseq_cnt = 0;
    int          rec_ncyc   = 0;
    logic [31:0] rec_addr   = 32'h0;
    logic [31:0] rec_first  = 32'h0;
    logic [31:0] rec_wdata  = 32'h0;
    logic        rec_write  = 1'b0;

    typedef struct packed {
        logic [71:0] frm;
        logic [3:0]  nfrm;
        logic [3:0]  dw;
        logic [3:0]  aw;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] tx;
        logic [2:0]  ntx;
        logic        nx;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
    } vec_t;

    vec_t  vecs[8];
    string vnames[8];

    function automatic vec_t mkv(input logic [71:0] f, input int nf, input int dw, input int aw,
                                 input logic err, input logic [31:0] rd, input logic [31:0] t,
                                 input int nt, input logic nx, input logic [31:0] a,
                                 input logic w, input logic [31:0] wd);
        vec_t v;
        v.frm = f; v.nfrm = 4'(nf); v.dw = 4'(dw); v.aw = 4'(aw); v.err = err;
        v.rdata = rd; v.tx = t; v.ntx = 3'(nt); v.nx = nx; v.addr = a; v.wr = w; v.wd = wd;
        return v;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Behavioural AHB-Lite slave: decides HREADY/HRESP/HRDATA 2 time units after each edge.
    initial begin
        int   sl_cnt, sl_acnt;
        logic sl_dphase, p_reset, p_nonseq, p_ready, p_d;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0BAD_0BAD;
        sl_cnt = 0; sl_acnt = 0; sl_dphase = 1'b0;
        p_reset = 1'b1; p_nonseq = 1'b0; p_ready = 1'b1; p_d = 1'b0;
        forever begin
            @(posedge HCLK);
            #2;
            if (p_reset) begin
                sl_dphase = 1'b0; sl_cnt = 0; sl_acnt = 0;
            end else begin
                if (p_d) begin
                    if (p_ready) sl_dphase = 1'b0;
                    else         sl_cnt++;
                end
                if (p_nonseq) begin
                    if (p_ready) begin sl_dphase = 1'b1; sl_cnt = 0; sl_acnt = 0; end
                    else sl_acnt++;
                end
            end
            HRDATA = 32'h0BAD_0BAD;
            if (sl_dphase) begin
                if (sl_cnt < int'(cfg_dw)) begin
                    HREADY = 1'b0;
                    HRESP  = cfg_err && (sl_cnt == int'(cfg_dw) - 1);
                end else begin
                    HREADY = 1'b1;
                    HRESP  = cfg_err;
                    HRDATA = cfg_rdata;
                    rec_wdata = HWDATA;
                end
            end else if (HTRANS == 2'b10) begin
                HRESP = 1'b0;
                if (sl_acnt == 0) rec_first = HADDR;
                HREADY = (sl_acnt >= int'(cfg_aw));
                if (HREADY) begin
                    nonseq_cnt++;
                    rec_addr  = HADDR;
                    rec_write = HWRITE;
                    rec_ncyc  = sl_acnt + 1;
                end
            end else begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
            p_reset = HRESET; p_nonseq = (HTRANS == 2'b10); p_ready = HREADY; p_d = sl_dphase;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic expect_tx(input logic [7:0] exp, input string name);
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin tick(); n++; end
        if (n >= 50) chk({name, ".tx_valid_wait"}, {31'b0, tx_valid}, 32'd1);
        chk(name, {24'b0, tx_data}, {24'b0, exp});
        tick();
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int base;
        logic [7:0] b;
        cfg_dw = v.dw; cfg_aw = v.aw; cfg_err = v.err; cfg_rdata = v.rdata;
        base = nonseq_cnt;
        for (int i = 0; i < int'(v.nfrm); i++) begin
            b = v.frm[71 - 8*i -: 8];
            send_byte(b);
        end
        for (int k = 0; k < int'(v.ntx); k++) begin
            b = v.tx[31 - 8*k -: 8];
            expect_tx(b, $sformatf("%s.tx%0d", nm, k));
        end
        tick();
        tick();
        chk({nm, ".xfers"}, 32'(nonseq_cnt - base), {31'b0, v.nx});
        if (v.nx) begin
            chk({nm, ".haddr"}, rec_addr, v.addr);
            chk({nm, ".haddr_held"}, rec_first, v.addr);
            chk({nm, ".hwrite"}, {31'b0, rec_write}, {31'b0, v.wr});
            chk({nm, ".nonseq_cycles"}, 32'(rec_ncyc), 32'(v.aw) + 32'd1);
            if (v.wr) chk({nm, ".hwdata"}, rec_wdata, v.wd);
        end
        chk({nm, ".extra_tx"}, {31'b0, tx_valid}, 32'd0);
        chk({nm, ".busy"}, {31'b0, busy}, 32'd0);
        chk({nm, ".rx_ready"}, {31'b0, rx_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] first;
        logic       stable;
        vecs[0] = mkv({8'h57,8'h40,8'h00,8'h00,8'h10,8'hDE,8'hAD,8'hBE,8'hEF}, 9, 0, 0, 1'b0,
                      32'h0, 32'h4B00_0000, 1, 1'b1, 32'h4000_0010, 1'b1, 32'hDEAD_BEEF);
        vnames[0] = "wr_basic";
        vecs[1] = mkv({8'h52,8'h40,8'h00,8'h00,8'h10,32'h0}, 5, 0, 3, 1'b0,
                      32'h1234_5678, 32'h1234_5678, 4, 1'b1, 32'h4000_0010, 1'b0, 32'h0);
        vnames[1] = "rd_addr_wait";
        vecs[2] = mkv({8'h52,8'h00,8'h00,8'h00,8'h02,32'h0}, 5, 0, 0, 1'b0,
                      32'h0, 32'hE100_0000, 1, 1'b0, 32'h0, 1'b0, 32'h0);
        vnames[2] = "rd_unaligned";
        vecs[3] = mkv({8'h33,64'h0}, 1, 0, 0, 1'b0,
                      32'h0, 32'h3F00_0000, 1, 1'b0, 32'h0, 1'b0, 32'h0);
        vnames[3] = "bad_opcode";
        vecs[4] = mkv({8'h57,8'h40,8'h00,8'h00,8'h20,8'h11,8'h22,8'h33,8'h44}, 9, 1, 0, 1'b1,
                      32'h0, 32'hE000_0000, 1, 1'b1, 32'h4000_0020, 1'b1, 32'h1122_3344);
        vnames[4] = "wr_bus_err";
        vecs[5] = mkv({8'h57,8'h00,8'h00,8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD}, 9, 0, 0, 1'b0,
                      32'h0, 32'hE100_0000, 1, 1'b0, 32'h0, 1'b0, 32'h0);
        vnames[5] = "wr_unaligned";
        vecs[6] = mkv({8'h52,8'h00,8'h00,8'h10,8'h04,32'h0}, 5, 2, 0, 1'b1,
                      32'h5555_AAAA, 32'hE000_0000, 1, 1'b1, 32'h0000_1004, 1'b0, 32'h0);
        vnames[6] = "rd_bus_err";
        vecs[7] = mkv({8'h52,8'h12,8'h34,8'h56,8'h78,32'h0}, 5, 3, 0, 1'b0,
                      32'hA55A_0FF0, 32'hA55A_0FF0, 4, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
        vnames[7] = "rd_data_wait";

        HRESET = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        tick(); tick();
        chk("rst.htrans", {30'b0, HTRANS}, 32'd0);
        chk("rst.haddr", HADDR, 32'd0);
        chk("rst.hwrite", {31'b0, HWRITE}, 32'd0);
        chk("rst.hwdata", HWDATA, 32'd0);
        chk("rst.tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst.tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst.rx_ready", {31'b0, rx_ready}, 32'd1);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("const.hsize_hburst_hprot", {22'b0, HSIZE, HBURST, HPROT}, {22'b0, 3'b010, 3'b000, 4'b0011});
        HRESET = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], vnames[i]);

        // Minimum latency with a zero-wait slave.
        cfg_dw = 4'd0; cfg_aw = 4'd0; cfg_err = 1'b0;
        send_byte(8'h57); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("lat.n1_nonseq", {30'b0, HTRANS}, 32'd2);
        tick();
        chk("lat.n2_idle", {30'b0, HTRANS}, 32'd0);
        chk("lat.n2_hwdata", HWDATA, 32'hDEAD_BEEF);
        chk("lat.n2_no_tx", {31'b0, tx_valid}, 32'd0);
        tick();
        chk("lat.n3_tx_valid", {31'b0, tx_valid}, 32'd1);
        chk("lat.n3_tx_data", {24'b0, tx_data}, 32'h4B);
        tick();
        chk("lat.done_busy", {31'b0, busy}, 32'd0);

        // Partial frame then silence: silent abort after TO idle cycles.
        send_byte(8'h57); send_byte(8'h40); send_byte(8'h00);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to.still_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("to.aborted", {31'b0, busy}, 32'd0);
        chk("to.no_tx", {31'b0, tx_valid}, 32'd0);
        apply_vec(vecs[1], "to_then_read");

        // Transmitter back-pressure during a read response.
        cfg_dw = 4'd0; cfg_aw = 4'd0; cfg_err = 1'b0; cfg_rdata = 32'hCAFE_F00D;
        tx_ready = 1'b0;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        for (int n = 0; n < 20 && !tx_valid; n++) tick();
        first = tx_data;
        stable = tx_valid;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_data !== first || tx_valid !== 1'b1) stable = 1'b0;
        end
        chk("stall.first", {24'b0, first}, 32'hCA);
        chk("stall.stable", {31'b0, stable}, 32'd1);
        tx_ready = 1'b1;
        expect_tx(8'hCA, "stall.b0");
        expect_tx(8'hFE, "stall.b1");
        expect_tx(8'hF0, "stall.b2");
        expect_tx(8'h0D, "stall.b3");
        tick();
        chk("stall.busy", {31'b0, busy}, 32'd0);

        // Reset while the slave is stalling the data phase.
        cfg_dw = 4'd5; cfg_aw = 4'd0; cfg_err = 1'b0;
        send_byte(8'h57); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick();
        chk("rmid.in_data_phase", {30'b0, HTRANS, busy}, {30'b0, 2'b00, 1'b1});
        chk("rmid.hwdata_before", HWDATA, 32'h0102_0304);
        HRESET = 1'b1;
        tick();
        chk("rmid.htrans", {30'b0, HTRANS}, 32'd0);
        chk("rmid.haddr", HADDR, 32'd0);
        chk("rmid.hwrite", {31'b0, HWRITE}, 32'd0);
        chk("rmid.hwdata", HWDATA, 32'd0);
        chk("rmid.tx", {23'b0, tx_valid, tx_data}, 32'd0);
        chk("rmid.rx_ready_busy", {30'b0, rx_ready, busy}, 32'd2);
        HRESET = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("rmid.no_late_resp", {31'b0, tx_valid}, 32'd0);
        apply_vec(vecs[0], "after_reset_write");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
